seq_generator: RTL

Serial pattern transmitter: the transmit-side counterpart of the 1011 sequence detector. It loads a WIDTH-bit pattern and shifts it out MSB-first on a single-bit line, one bit per clock. It optionally repeats the pattern with programmable zero-gaps between copies. It drives detector inputs in loopback benches and serves as the stimulus source for serial-protocol blocks in the same design.

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/seq_generator_piso_shift.sv | 50 +++++
 rtl/seq_generator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Shared definitions for the serial pattern transmitter and the 1011
//   sequence detector bench that consumes its output.
//
//   Contents:
//     state_e       - transmitter FSM states (IDLE, SHIFT, GAP, DONE)
//     PAT_1011      - default 4-bit pattern recognised by the detector
//     DEF_WIDTH     - default pattern length
//     DEF_GAP_BITS  - default number of zero bits between copies
//     DEF_CNT_W     - default width of the repeat count
//     cnt_width()   - counter width helper, never returns less than 1
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] PAT_1011 = 4'b1011;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_GAP_BITS = 0;
  localparam int DEF_CNT_W    = 4;

  // Width needed to hold values 0..n-1. A zero-width counter is not legal,
  // so degenerate cases (n <= 2) collapse to a single bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : seq_pkg

// File: rtl/seq_generator_piso_shift.sv
// ---------------------------------------------------------------------------
// piso_shift
//   Parallel-in serial-out shift register. The most significant bit is
//   presented on msb; each shift moves the register left by one and fills
//   the vacated LSB with 0.
//
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   synchronous active-low clear
//     load      in   capture data into the register (wins over shift_en)
//     shift_en  in   shift left by one position
//     data      in   WIDTH-bit parallel load value
//     msb       out  current most significant bit of the register
// ---------------------------------------------------------------------------
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] shReg_q;
  logic [WIDTH-1:0] shReg_d;

  // Load has priority so a reload on the last bit of a copy never gets
  // overridden by a stray shift request in the same cycle.
  always_comb begin
    shReg_d = shReg_q;
    if (load) begin
      shReg_d = data;
    end else if (shift_en) begin
      shReg_d = {shReg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shReg_q <= '0;
    end else begin
      shReg_q <= shReg_d;
    end
  end

  assign msb = shReg_q[WIDTH-1];

endmodule : piso_shift

// File: rtl/seq_generator.sv
// ---------------------------------------------------------------------------
// seq_generator
//   Serial pattern transmitter. On an accepted start it captures a WIDTH-bit
//   pattern and a repeat count, then sends repeat_cnt+1 copies of the pattern
//   MSB-first, one bit per clock, with GAP_BITS zero bits between copies.
//   A single-cycle done pulse follows the last frame bit.
//
//   Parameters:
//     WIDTH     pattern length in bits (2..16)
//     GAP_BITS  zero bits inserted between consecutive copies (0..15)
//     CNT_W     width of repeat_cnt
//
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   synchronous active-low reset
//     start       in   transmit request, only looked at while idle
//     pattern     in   bits to send, MSB first, captured on start
//     repeat_cnt  in   extra copies to send, captured on start
//     out         out  serial data bit
//     bit_valid   out  high while out carries a frame bit (pattern or gap)
//     busy        out  high for the whole frame
//     done        out  one-cycle pulse after the last frame bit
//
//   Every output is decoded purely from flops (FSM state and shift register
//   MSB), so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module seq_generator
  import seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int GAP_BITS = DEF_GAP_BITS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP_BITS + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam bit               HAS_GAP  = (GAP_BITS > 0);

  state_e           state_q,  state_d;
  logic [BIT_W-1:0] bitCnt_q, bitCnt_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic [CNT_W-1:0] copies_q, copies_d;
  logic [WIDTH-1:0] pat_q,    pat_d;

  logic             shLoad;
  logic             shShift;
  logic [WIDTH-1:0] shData;
  logic             shMsb;

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (shLoad),
    .shift_en (shShift),
    .data     (shData),
    .msb      (shMsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and pattern registers. Cleared on reset so an aborted frame
  // leaves nothing behind for the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bitCnt_q <= '0;
      gapCnt_q <= '0;
      copies_q <= '0;
      pat_q    <= '0;
    end else begin
      bitCnt_q <= bitCnt_d;
      gapCnt_q <= gapCnt_d;
      copies_q <= copies_d;
      pat_q    <= pat_d;
    end
  end

  // Next-state and datapath control.
  // copies_q holds the number of copies still to send after the current one;
  // it is only decremented when a reload actually happens, and a reload only
  // happens while it is non-zero, so it can never wrap.
  // With GAP_BITS = 0 the last bit of a copy reloads the shift register
  // directly, so consecutive copies come out with no bubble.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    gapCnt_d = gapCnt_q;
    copies_d = copies_q;
    pat_d    = pat_q;
    shLoad   = 1'b0;
    shShift  = 1'b0;
    shData   = pat_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d    = pattern;
          copies_d = repeat_cnt;
          shData   = pattern;
          shLoad   = 1'b1;
          bitCnt_d = '0;
          gapCnt_d = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (bitCnt_q != LAST_BIT) begin
          shShift  = 1'b1;
          bitCnt_d = bitCnt_q + 1'b1;
        end else if (copies_q != '0) begin
          bitCnt_d = '0;
          if (HAS_GAP) begin
            gapCnt_d = '0;
            state_d  = GAP;
          end else begin
            shLoad   = 1'b1;
            copies_d = copies_q - 1'b1;
          end
        end else begin
          bitCnt_d = '0;
          state_d  = DONE;
        end
      end

      GAP: begin
        if (gapCnt_q == LAST_GAP) begin
          shLoad   = 1'b1;
          copies_d = copies_q - 1'b1;
          gapCnt_d = '0;
          state_d  = SHIFT;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode (Moore): only SHIFT puts pattern data on the line; GAP
  // drives zeros that still count as frame bits.
  always_comb begin
    out       = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      SHIFT: begin
        out       = shMsb;
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      GAP: begin
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule : seq_generator
